serial_adder: RTL and testbench

// - Bit-serial WIDTH-bit adder. It consumes the sum/carry primitive of the half-adder stage.
// - Each step is built as a full adder from two half adders plus a carry flip-flop.
// - Operands are captured on start and added LSB-first, one bit per clock.
// - The registered sum and carry-out are presented with a one-cycle done pulse.
// - Sits between the tile's operand inputs (ui_in/uio_in) and uo_out in the top-level wrapper.

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit unsigned adder. Operands are captured on an accepted
//   start and added LSB-first, one bit per clock. Each bit step is a full
//   adder built from two half adders plus a carry flip-flop. The registered
//   sum and carry-out are presented together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/sum width in bits (legal 1..16)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      capture a/b and begin an addition (ignored while busy)
//   a      in   WIDTH  operand A, sampled only on an accepted start
//   b      in   WIDTH  operand B, sampled only on an accepted start
//   busy   out  1      high while bits are being shifted
//   done   out  1      one-cycle pulse: sum/cout valid from this cycle
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered carry-out of the MSB, held with sum
// -----------------------------------------------------------------------------

// Half-adder primitive shared by both stages of the bit-serial full adder.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic p, g1, s, g2;
    logic             carry_next;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;

    half_adder u_ha1 (
        .x (sa[0]),
        .y (sb[0]),
        .s (p),
        .c (g1)
    );

    half_adder u_ha2 (
        .x (p),
        .y (carry),
        .s (s),
        .c (g2)
    );

    assign carry_next = g1 | g2;
    // New sum bit enters at the MSB; shifting the concatenation keeps the
    // expression legal for WIDTH == 1, where it reduces to just s.
    assign acc_next   = WIDTH'({s, acc} >> 1);
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; the internal shift registers are reset too, so
    // no stale operand bits survive a reset that aborts an addition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE, giving back-to-back
                // operation at one result every WIDTH+1 cycles.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    carry <= carry_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    // Outputs change only on the completing edge, so partial
                    // sums never reach the ports.
                    if (last_bit) begin
                        sum   <= acc_next;
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. An 8-bit instance covers directed
//   cases, ignored start, back-to-back starts, reset abort and a random
//   regression; a 1-bit instance covers the minimum width. Expected results
//   come from plain a+b arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1;
    logic [0:0]   a1, b1, sum1;
    logic         busy1, done1, cout1;

    int checks;
    int errors;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done on the 8-bit DUT; n carries in the cycles already spent.
    task automatic wait_done8(inout int n);
        while (done !== 1'b1 && n < 100) begin
            check("busy_done_excl", {31'b0, busy & done}, 32'd0);
            tick();
            n++;
        end
    endtask

    // One addition on the 8-bit DUT with a single-cycle start pulse.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int         n;
        logic [W:0] ref_v;
        ref_v = {1'b0, x} + {1'b0, y};
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        n = 0;
        wait_done8(n);
        check({tag, "_latency"}, n, W);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_sum"}, {24'b0, sum}, {24'b0, ref_v[W-1:0]});
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, ref_v[W]});
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_hold_sum"}, {24'b0, sum}, {24'b0, ref_v[W-1:0]});
    endtask

    // One addition on the 1-bit DUT: done expected two cycles after start.
    task automatic run_add1(input logic x, input logic y);
        logic [1:0] ref_v;
        ref_v = {1'b0, x} + {1'b0, y};
        a1 = x; b1 = y; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", {31'b0, busy1}, 32'd1);
        check("w1_no_early_done", {31'b0, done1}, 32'd0);
        tick();
        check("w1_done", {31'b0, done1}, 32'd1);
        check("w1_busy_low", {31'b0, busy1}, 32'd0);
        check("w1_sum", {31'b0, sum1}, {31'b0, ref_v[0]});
        check("w1_cout", {31'b0, cout1}, {31'b0, ref_v[1]});
        tick();
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {24'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_w1_sum", {31'b0, sum1}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Directed cases
        run_add(8'h5A, 8'h3C, "5a_3c");
        run_add(8'hFF, 8'h01, "ff_01");
        run_add(8'hFF, 8'hFF, "ff_ff");
        run_add(8'h00, 8'h00, "00_00");

        // start during SHIFT cycle 3 with new operands must be ignored
        a = 8'h12; b = 8'h34; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00;
        n = 3;
        wait_done8(n);
        check("ign_latency", n, 8);
        check("ign_sum", {24'b0, sum}, 32'h46);
        check("ign_cout", {31'b0, cout}, 32'd0);
        tick();
        check("ign_no_requeue", {30'b0, busy, done}, 32'd0);

        // start held high: back-to-back additions every WIDTH+1 cycles
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        a = 8'h80; b = 8'h80;
        n = 0;
        wait_done8(n);
        check("b2b1_latency", n, 8);
        check("b2b1_sum", {24'b0, sum}, 32'h02);
        check("b2b1_cout", {31'b0, cout}, 32'd0);
        tick();
        check("b2b_busy_after_done", {30'b0, busy, done}, 32'd2);
        n = 1;
        wait_done8(n);
        check("b2b2_period", n, 9);
        check("b2b2_sum", {24'b0, sum}, 32'h00);
        check("b2b2_cout", {31'b0, cout}, 32'd1);
        start = 1'b0;
        tick();
        check("b2b_stop", {30'b0, busy, done}, 32'd0);

        // Reset at SHIFT cycle 4 aborts the addition
        run_add(8'hA5, 8'h0F, "pre_rst");
        a = 8'h77; b = 8'h99; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", {24'b0, sum}, 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_quiet", {30'b0, busy, done}, 32'd0);
        end
        run_add(8'h77, 8'h99, "post_rst");

        // Minimum width
        run_add1(1'b1, 1'b1);
        run_add1(1'b0, 1'b0);
        run_add1(1'b1, 1'b0);
        run_add1(1'b0, 1'b1);

        // Random regression against a+b
        for (int i = 0; i < 1000; i++) begin
            run_add(W'($urandom), W'($urandom), "rand");
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
